// File: rtl/softmax_stream.sv
// softmax_stream: streaming softmax over N-element vectors of signed Q(XW-12).12 inputs
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_data one element per beat (XW bits)
//   out_valid/out_ready  output handshake, out_data Q0.OW probability, out_last on element N-1
//   busy                 high whenever the block is not in LOAD
module softmax_stream #(
    parameter int N  = 8,
    parameter int XW = 17,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);
    localparam int LW = $clog2(N);
    localparam int SW = 16 + LW;
    localparam int BW = XW > 16 ? XW : 16;
    localparam int CW = $clog2(OW + 2);
    localparam logic [1:0] LOAD = 2'd0, EXP = 2'd1, DIV = 2'd2, OUT = 2'd3;
    localparam logic [LW:0] LAST = (LW + 1)'(N - 1);
    localparam logic [CW-1:0] DLAST = CW'(OW);
    localparam logic signed [XW-1:0] XMIN = {1'b1, {(XW - 1){1'b0}}};
    // round(e^-k * 2^15) and round(e^(-j/16) * 2^15)
    localparam logic [15:0] T0 [16] = '{16'd32768, 16'd12055, 16'd4435, 16'd1631, 16'd600, 16'd221,
                                        16'd81, 16'd30, 16'd11, 16'd4, 16'd1, 16'd1,
                                        16'd0, 16'd0, 16'd0, 16'd0};
    localparam logic [15:0] T1 [16] = '{16'd32768, 16'd30783, 16'd28918, 16'd27166, 16'd25520, 16'd23974,
                                        16'd22521, 16'd21157, 16'd19875, 16'd18671, 16'd17539, 16'd16477,
                                        16'd15479, 16'd14541, 16'd13660, 16'd12832};

    logic [1:0]           state;
    logic [LW:0]          cnt;
    logic signed [XW-1:0] mx;
    logic [SW-1:0]        sum;
    logic [BW-1:0]        buffer [N];
    logic [SW:0]          rem;
    logic [OW:0]          quo;
    logic [CW-1:0]        dcnt;
    logic                 s1_v, s2_v, s1_z;
    logic [LW-1:0]        s1_idx, s2_idx;
    logic [15:0]          s1_p, s1_lin, s2_e;

    logic          take, issue, ge;
    logic [XW-1:0] x;
    logic [XW:0]   mag;
    logic [31:0]   m32;
    logic [SW:0]   diff;
    logic [OW:0]   q_nxt;

    assign busy      = state != LOAD;
    assign out_valid = state == OUT;
    assign take      = in_valid && in_ready && state == LOAD;
    assign issue     = state == EXP && !cnt[LW];
    assign x         = buffer[cnt[LW-1:0]][XW-1:0];
    // max - x is the magnitude of the non-positive difference d
    assign mag       = {mx[XW-1], mx} - {x[XW-1], x};
    assign m32       = 32'(mag);
    assign ge        = rem >= {1'b0, sum};
    assign diff      = ge ? rem - {1'b0, sum} : rem;
    assign q_nxt     = {quo[OW-1:0], ge};

    // Exp pipeline and element buffer; these need no reset
    always_ff @(posedge clk) begin
        if (take) buffer[cnt[LW-1:0]] <= BW'(in_data);
        if (s2_v) buffer[s2_idx] <= BW'(s2_e);
        s1_p   <= 16'((32'(T0[m32[15:12]]) * 32'(T1[m32[11:8]])) >> 15);
        s1_lin <= 16'h8000 - {5'd0, m32[7:0], 3'd0};
        s1_z   <= |m32[31:16];
        s1_idx <= cnt[LW-1:0];
        s2_e   <= s1_z ? 16'd0 : 16'((32'(s1_p) * 32'(s1_lin)) >> 15);
        s2_idx <= s1_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            cnt      <= '0;
            mx       <= XMIN;
            sum      <= '0;
            in_ready <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            dcnt     <= '0;
        end else begin
            s1_v     <= issue;
            s2_v     <= s1_v;
            // after the final output handshake the block is back in LOAD, ready next cycle
            in_ready <= (state == LOAD && !(take && cnt == LAST)) || (state == OUT && out_ready && out_last);
            case (state)
                LOAD: if (take) begin
                    mx    <= $signed(in_data) > mx ? in_data : mx;
                    cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
                    state <= cnt == LAST ? EXP : LOAD;
                end
                EXP: begin
                    if (issue) cnt <= cnt + 1'b1;
                    if (s2_v) sum <= sum + SW'(s2_e);
                    if (s2_v && s2_idx == LAST[LW-1:0]) begin
                        state <= DIV;
                        cnt   <= '0;
                        rem   <= (SW + 1)'(buffer[0][15:0]);
                        quo   <= '0;
                        dcnt  <= '0;
                    end
                end
                // restoring division of e*2^OW by sum, one quotient bit per cycle MSB first
                DIV: begin
                    rem  <= {diff[SW-1:0], 1'b0};
                    quo  <= q_nxt;
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DLAST) begin
                        state    <= OUT;
                        out_data <= q_nxt[OW] ? {OW{1'b1}} : q_nxt[OW-1:0];
                        out_last <= cnt == LAST;
                    end
                end
                default: if (out_ready) begin
                    if (out_last) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        mx       <= XMIN;
                        sum      <= '0;
                        out_last <= 1'b0;
                    end else begin
                        state <= DIV;
                        cnt   <= cnt + 1'b1;
                        rem   <= (SW + 1)'(buffer[cnt[LW-1:0] + LW'(1)][15:0]);
                        quo   <= '0;
                        dcnt  <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_stream.sv
// tb_softmax_stream: randomized and directed check of softmax_stream against a behavioural model
module tb_softmax_stream;
    localparam int N = 8, XW = 17, OW = 16;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [XW-1:0] in_data = '0;
    logic in_ready, out_valid, out_last, busy;
    logic [OW-1:0] out_data;

    softmax_stream #(.N(N), .XW(XW), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_acc = 0;
    int t0[16], t1[16];
    int exp_q[$];
    longint osum = 0;
    bit stall_mode = 0;

    task automatic chk(input string nm, input longint got, input longint want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
        end
    endtask

    function automatic int exp_of(input int m);
        if (m >= 65536) return 0;
        return (((t0[m / 4096] * t1[(m / 256) % 16]) >> 15) * (32768 - (m % 256) * 8)) >> 15;
    endfunction

    task automatic model(input int x[N], output int q[N]);
        int mx = x[0];
        int e[N];
        longint s = 0;
        foreach (x[i]) if (x[i] > mx) mx = x[i];
        foreach (x[i]) begin
            e[i] = exp_of(mx - x[i]);
            s += e[i];
        end
        foreach (x[i]) begin
            q[i] = int'((longint'(e[i]) << 16) / s);
            if (q[i] > 65535) q[i] = 65535;
        end
    endtask

    task automatic push_q(input int q[N]);
        for (int i = 0; i < N; i++) exp_q.push_back(q[i] | ((i == N - 1) ? 32'h10000 : 0));
    endtask

    task automatic send(input int x[N]);
        for (int i = 0; i < N; i++) begin
            int to = 0;
            in_valid = 1'b1;
            in_data  = x[i][XW-1:0];
            while (!in_ready && to < 3000) begin
                @(negedge clk);
                to++;
            end
            if (to >= 3000) chk("in_ready_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = XW'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic rand_vec(output int x[N]);
        int base = int'($urandom_range(0, 131071)) - 65536;
        int r;
        case ($urandom_range(0, 3))
            0: r = 4096;
            1: r = 20000;
            2: r = 70000;
            default: r = 131071;
        endcase
        for (int i = 0; i < N; i++) begin
            x[i] = base - int'($urandom_range(0, r));
            if (x[i] < -65536) x[i] = -65536;
        end
    endtask

    // Output sink: every valid cycle is compared against the queue head, so held or
    // changed data, skipped or repeated elements all show up as wrong values.
    initial begin
        int hold = 0;
        bit fresh = 1, chk_rdy = 0;
        forever begin
            @(negedge clk);
            if (chk_rdy) begin
                chk("in_ready_after_last", in_ready, 1);
                chk("busy_after_last", busy, 0);
                chk_rdy = 0;
            end
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got data 0x%0h with nothing expected", out_data);
                    out_ready = 1'b1;
                end else begin
                    chk("out_data", out_data, exp_q[0] & 32'hFFFF);
                    chk("out_last", out_last, exp_q[0] >> 16);
                    chk("in_ready_during_out", in_ready, 0);
                    if (fresh) begin
                        hold  = stall_mode ? 20 : 0;
                        fresh = 0;
                    end
                    if (hold > 0) begin
                        hold--;
                        out_ready = 1'b0;
                    end else out_ready = $urandom_range(0, 3) != 0;
                    if (out_ready) begin
                        osum += out_data;
                        if (out_last) begin
                            chk("prob_sum_near_one", (osum > 65536 - N) && (osum <= 65536), 1);
                            osum    = 0;
                            chk_rdy = 1;
                        end
                        void'(exp_q.pop_front());
                        n_acc++;
                        fresh = 1;
                    end
                end
            end else out_ready = $urandom_range(0, 1) != 0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[N], q[N];
        int base, cv;
        for (int k = 0; k < 16; k++) begin
            t0[k] = int'($floor($exp(-real'(k)) * 32768.0 + 0.5));
            t1[k] = int'($floor($exp(-real'(k) / 16.0) * 32768.0 + 0.5));
        end
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("in_ready_first_edge", in_ready, 1);

        // hand-computed pins on the model itself
        v = '{default: 0};
        model(v, q);
        chk("model_zeros", q[3], 16'h2000);
        v = '{default: -40960};
        v[0] = 40960;
        model(v, q);
        chk("model_sat", q[0], 16'hFFFF);
        chk("model_sat_rest", q[1], 0);
        v = '{default: -65536};
        v[0] = 0;
        v[1] = -4096;
        model(v, q);
        chk("model_pin0", q[0], 47910);
        chk("model_pin1", q[1], 17625);
        chk("model_d_minus16", q[2], 0);

        // directed vectors with literal expectations
        q = '{default: 16'h2000};
        push_q(q);
        v = '{default: 0};
        send(v);
        q = '{default: 0};
        q[0] = 16'hFFFF;
        push_q(q);
        v = '{default: -40960};
        v[0] = 40960;
        send(v);
        q = '{default: 0};
        q[0] = 47910;
        q[1] = 17625;
        push_q(q);
        v = '{default: -65536};
        v[0] = 0;
        v[1] = -4096;
        send(v);
        wait_drain();
        stall_mode = 1;
        q = '{default: 16'h2000};
        push_q(q);
        v = '{default: 14336};
        send(v);
        wait_drain();
        stall_mode = 0;

        // reset during the division of element 3
        rand_vec(v);
        model(v, q);
        push_q(q);
        base = n_acc;
        send(v);
        for (int t = 0; t < 3000 && n_acc < base + 3; t++) @(negedge clk);
        chk("reached_elem3", n_acc, base + 3);
        repeat (5) @(negedge clk);
        chk("busy_in_div", busy, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        osum = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        cv = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (out_valid) cv++;
        end
        chk("no_valid_after_rst", cv, 0);
        q = '{default: 16'h2000};
        push_q(q);
        v = '{default: -7000};
        send(v);

        for (int n = 0; n < 12; n++) begin
            rand_vec(v);
            model(v, q);
            push_q(q);
            send(v);
        end
        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
